vga_scan_timer: RTL and testbench

Raster timing source for the VGA path. Divides the system clock to a pixel rate, runs horizontal and vertical scan counters, and drives the pixel coordinate bus (`x`, `y`) and active-video flag (`enb`) consumed by every rectangle/overlay generator, together with the monitor sync pulses. All outputs are registered, so downstream combinational colour logic sees glitch-free, mutually aligned coordinates and syncs.

---
 rtl/vga_scan_timer.sv | 103 ++++++++++
 tb/tb_vga_scan_timer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_timer.sv
// VGA raster timing: pixel-rate divider, horizontal/vertical scan counters and
// registered, mutually aligned coordinate, active-video, sync and strobe outputs.
module vga_scan_timer #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        enb,
    output logic        hsync,
    output logic        vsync,
    output logic        pix_tick,
    output logic        line_start,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_reg;
    logic          adv;
    logic [10:0]   h_reg, v_reg;
    logic [10:0]   h_next, v_next;
    logic          div_zero, hs_on, vs_on;

    // With CLK_DIV = 1 the divider collapses to a constant and every clock is a pixel.
    generate
        if (CLK_DIV > 1) begin : g_div
            always_ff @(posedge clk) begin
                if (!rst_n)
                    div_reg <= '0;
                else if (adv)
                    div_reg <= '0;
                else
                    div_reg <= div_reg + DW'(1);
            end
            assign adv = (div_reg == DW'(CLK_DIV - 1));
        end else begin : g_nodiv
            assign div_reg = '0;
            assign adv     = 1'b1;
        end
    endgenerate

    always_comb begin
        h_next = h_reg;
        v_next = v_reg;
        if (adv) begin
            if (h_reg == 11'(H_TOTAL - 1)) begin
                h_next = '0;
                v_next = (v_reg == 11'(V_TOTAL - 1)) ? 11'd0 : v_reg + 11'd1;
            end else begin
                h_next = h_reg + 11'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_reg <= '0;
            v_reg <= '0;
        end else begin
            h_reg <= h_next;
            v_reg <= v_next;
        end
    end

    assign div_zero = (div_reg == '0);
    assign hs_on    = (h_reg >= 11'(H_ACTIVE + H_FP)) && (h_reg < 11'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_on    = (v_reg >= 11'(V_ACTIVE + V_FP)) && (v_reg < 11'(V_ACTIVE + V_FP + V_SYNC));

    // All outputs are sampled from the same counter state, so they stay aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            enb         <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            x           <= h_reg;
            y           <= v_reg;
            enb         <= (h_reg < 11'(H_ACTIVE)) && (v_reg < 11'(V_ACTIVE));
            hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
            pix_tick    <= div_zero;
            line_start  <= div_zero && (h_reg == '0);
            frame_start <= div_zero && (h_reg == '0) && (v_reg == '0);
        end
    end
endmodule

// File: tb/tb_vga_scan_timer.sv
// Bench for vga_scan_timer: three instances (small/div2, small/div1/positive sync,
// default geometry) checked every clock against a closed-form time-based model.
module tb_vga_scan_timer;
    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        enb;
        logic        hs;
        logic        vs;
        logic        pt;
        logic        ls;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
    logic [10:0] xa, ya, xb, yb, xc, yc;
    logic ena, hsa, vsa, pta, lsa, fsa;
    logic enbb, hsb, vsb, ptb, lsb, fsb;
    logic enc, hsc, vsc, ptc, lsc, fsc;

    int vectors = 0;
    int miscompares = 0;

    vga_scan_timer #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_a), .x(xa), .y(ya), .enb(ena), .hsync(hsa), .vsync(vsa),
        .pix_tick(pta), .line_start(lsa), .frame_start(fsa));

    vga_scan_timer #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_b), .x(xb), .y(yb), .enb(enbb), .hsync(hsb), .vsync(vsb),
        .pix_tick(ptb), .line_start(lsb), .frame_start(fsb));

    vga_scan_timer dut_c (
        .clk(clk), .rst_n(rst_c), .x(xc), .y(yc), .enb(enc), .hsync(hsc), .vsync(vsc),
        .pix_tick(ptc), .line_start(lsc), .frame_start(fsc));

    // Expected outputs from the number of clocks k since reset release (k < 0: in reset).
    function automatic obs_t model(input int k, input int d, input int ha, input int hf,
                                   input int hsw, input int hb, input int va, input int vf,
                                   input int vsw, input int vb, input bit pol);
        obs_t e;
        int ht, vt, p, h, v;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (k < 0) begin
            e = '0;
            e.hs = ~pol;
            e.vs = ~pol;
            return e;
        end
        p = k / d;
        h = p % ht;
        v = (p / ht) % vt;
        e.x   = 11'(h);
        e.y   = 11'(v);
        e.enb = (h < ha) && (v < va);
        e.hs  = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
        e.vs  = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
        e.pt  = (k % d) == 0;
        e.ls  = e.pt && (h == 0);
        e.fs  = e.ls && (v == 0);
        return e;
    endfunction

    function automatic obs_t model_def(input int k);
        return model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    endfunction

    task automatic check_obs(input string name, input int k, input obs_t got, input obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s k=%0d got x=%0d y=%0d enb=%b hs=%b vs=%b pt=%b ls=%b fs=%b want x=%0d y=%0d enb=%b hs=%b vs=%b pt=%b ls=%b fs=%b",
                     name, k, got.x, got.y, got.enb, got.hs, got.vs, got.pt, got.ls, got.fs,
                     exp.x, exp.y, exp.enb, exp.hs, exp.vs, exp.pt, exp.ls, exp.fs);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    // Clocks since release per instance, advanced on the same edge the DUT sees.
    int ka = -1, kb = -1, kc = -1;
    bit started = 1'b0;
    always @(posedge clk) begin
        ka <= rst_a ? ka + 1 : -1;
        kb <= rst_b ? kb + 1 : -1;
        kc <= rst_c ? kc + 1 : -1;
        started <= 1'b1;
    end

    // Frame/line statistics, gathered only during the first run after release.
    bit stats_on = 1'b1;
    int a_samp = 0, a_enb = 0, a_hs = 0, a_vs = 0, a_fs_cnt = 0, a_fs_second = -1;
    int b_pt = 0, b_hs = 0, b_ls_second = -1;
    int c_pt = 0, c_enb = 0, c_hs = 0, c_ls_second = -1;

    // Single per-cycle compare process against the model.
    always @(negedge clk) begin
        if (started) begin
            check_obs("inst_a", ka, {xa, ya, ena, hsa, vsa, pta, lsa, fsa},
                      model(ka, 2, 8, 2, 3, 2, 6, 1, 2, 1, 1'b0));
            check_obs("inst_b", kb, {xb, yb, enbb, hsb, vsb, ptb, lsb, fsb},
                      model(kb, 1, 8, 2, 3, 2, 6, 1, 2, 1, 1'b1));
            check_obs("inst_c", kc, {xc, yc, enc, hsc, vsc, ptc, lsc, fsc}, model_def(kc));
        end
        if (stats_on) begin
            if (ka >= 0 && ka < 300 && pta) begin
                a_samp++;
                if (ena) a_enb++;
                if (!hsa) a_hs++;
                if (!vsa) a_vs++;
            end
            if (ka >= 0 && ka < 600 && fsa) begin
                a_fs_cnt++;
                if (ka > 0) a_fs_second = ka;
            end
            if (kb >= 0 && kb < 30 && ptb) b_pt++;
            if (kb >= 0 && kb < 15 && hsb) b_hs++;
            if (kb > 0 && lsb && b_ls_second < 0) b_ls_second = kb;
            if (kc >= 0 && kc < 1600) begin
                if (ptc) c_pt++;
                if (enc) c_enb++;
                if (!hsc) c_hs++;
            end
            if (kc > 0 && lsc && c_ls_second < 0) c_ls_second = kc;
        end
    end

    obs_t m;
    initial begin
        // Hand-computed pins of the model at default geometry.
        m = model_def(0);       check_int("pin_k0_fs", int'(m.fs), 1);
        m = model_def(1);       check_int("pin_k1_pt", int'(m.pt), 0);
        m = model_def(1311);    check_int("pin_x655", int'(m.x), 655); check_int("pin_x655_hs", int'(m.hs), 1);
        m = model_def(1312);    check_int("pin_x656_hs", int'(m.hs), 0);
        m = model_def(1600);    check_int("pin_line1_y", int'(m.y), 1); check_int("pin_line1_ls", int'(m.ls), 1);
        m = model_def(784000);  check_int("pin_y490_vs", int'(m.vs), 0); check_int("pin_y490_enb", int'(m.enb), 0);
        m = model_def(840000);  check_int("pin_frame2_fs", int'(m.fs), 1);
        m = model_def(839999);  check_int("pin_last_x", int'(m.x), 799); check_int("pin_last_y", int'(m.y), 524);

        repeat (3) @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (3400) @(negedge clk);
        stats_on = 1'b0;

        check_int("a_frame_samples", a_samp, 150);
        check_int("a_frame_enb", a_enb, 48);
        check_int("a_frame_hsync", a_hs, 30);
        check_int("a_frame_vsync", a_vs, 30);
        check_int("a_frame_start_count", a_fs_cnt, 2);
        check_int("a_frame_period", a_fs_second, 300);
        check_int("b_pix_tick_count", b_pt, 30);
        check_int("b_hsync_clocks", b_hs, 3);
        check_int("b_line_period", b_ls_second, 15);
        check_int("c_line_period", c_ls_second, 1600);
        check_int("c_line_pix_ticks", c_pt, 800);
        check_int("c_line_enb_clocks", c_enb, 1280);
        check_int("c_line_hsync_clocks", c_hs, 192);

        // Mid-frame reset on instance A at (5,4), first clock of the pixel.
        begin
            int i;
            for (i = 0; i < 1000 && !(xa == 11'd5 && ya == 11'd4 && pta); i++) @(negedge clk);
            check_int("a_reach_5_4", (xa == 11'd5 && ya == 11'd4 && pta) ? 1 : 0, 1);
        end
        rst_a = 1'b0;
        @(negedge clk);
        check_obs("a_in_reset", -1, {xa, ya, ena, hsa, vsa, pta, lsa, fsa},
                  {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        rst_a = 1'b1;
        @(negedge clk);
        check_obs("a_after_release", 0, {xa, ya, ena, hsa, vsa, pta, lsa, fsa},
                  {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
